cnn_result_readout: RTL and testbench
=====================================

// Module: cnn_result_readout
// PURPOSE
//   Parametrised prediction buffer and readout unit between the CNN accelerator and the board LEDs.
//   Captures up to DEPTH class IDs from the accelerator over a valid/ready stream and signals done.
//   Replays any entry by index (manual mode) or cycles through all entries (auto-scan mode).
//   Privacy masking: while unlock is low, the display shows LOCK_CODE instead of the real class.
// PARAMETERS
//   NUM_CLASSES  10          number of valid classes; any class ID >= NUM_CLASSES is invalid
//   CLASS_W      4           class ID width; must satisfy 2**CLASS_W > NUM_CLASSES
//   DEPTH        32          buffer entries (>= 2)
//   IDX_W        $clog2(DEPTH) index width
//   SCAN_DIV     50_000_000  clk cycles per auto-scan step (>= 1)
//   LOCK_CODE    4'hA        display code for locked, empty or invalid entries; must be >= NUM_CLASSES
// PORTS
//   clk         in   1          system clock
//   rst         in   1          synchronous, active-high reset
//   res_valid   in   1          accelerator prediction valid
//   res_ready   out  1          buffer can accept a prediction
//   res_class   in   CLASS_W    predicted class ID
//   res_last    in   1          qualifies the final prediction of the batch
//   unlock      in   1          1 = real classes visible; 0 = masked (driven by the security unit)
//   mode        in   2          00 off, 01 index readout, 10 auto-scan, 11 clear
//   sel_idx     in   IDX_W      entry to show in mode 01
//   disp_class  out  CLASS_W    registered class shown on the LEDs
//   disp_idx    out  IDX_W      registered index of the entry being shown
//   count       out  IDX_W+1    number of entries stored
//   done        out  1          batch complete
//   overflow    out  1          sticky: a prediction arrived while the buffer was READY (dropped)
// BEHAVIOUR
//   Reset: state=IDLE, count=0, done=0, overflow=0, disp_idx=0, disp_class=LOCK_CODE, scan ptr/div=0.
//   States: IDLE (empty) -> FILL (first write) -> READY (res_last accepted or count==DEPTH) -> IDLE (clear).
//   res_ready = (state IDLE|FILL) && count<DEPTH && mode!=11 && !rst; combinational from registers.
//   Write: on res_valid&&res_ready, mem[count] <= (res_class<NUM_CLASSES ? res_class : LOCK_CODE); count++.
//   Accept with res_last, or accept at count==DEPTH-1: the same edge moves to READY; done=1 next cycle.
//   READY: res_valid high -> overflow<=1, data dropped, count unchanged. done stays 1 until clear.
//   Clear (mode==11): takes effect at the next edge from any state; count/done/overflow/scan ptr <= 0,
//     state IDLE, disp_class=LOCK_CODE. Clear has priority over a simultaneous write.
//   Readout (registered, 1-cycle latency, valid in every state):
//     mode 00: disp_class=LOCK_CODE, disp_idx=0.
//     mode 01: disp_idx<=sel_idx; disp_class<=entry(sel_idx).
//     mode 10: disp_idx<=scan ptr; disp_class<=entry(scan ptr). Divider counts 0..SCAN_DIV-1; on wrap the
//       ptr advances and wraps count-1 -> 0. count==0 -> ptr held at 0. Outside mode 10, ptr and divider hold.
//     entry(i) = LOCK_CODE if unlock==0 or i>=count, else mem[i].
//   unlock toggles take effect on disp_class at the next edge; scanning continues while masked.
//   Memory contents are not reset; the i>=count guard masks stale data.
// TESTING
//   1) Reset, unlock=1, write 5 classes {3,7,1,9,0}, res_last on the 5th -> count=5, done=1 one cycle later.
//   2) mode=01, sel_idx=1,3,4,6 -> disp_class 7,9,0,LOCK_CODE (6>=count), each one cycle after sel_idx.
//   3) unlock=0 with sel_idx=1 -> disp_class=LOCK_CODE next cycle; unlock=1 -> 7 next cycle.
//   4) SCAN_DIV=4, mode=10, count=5 -> disp_idx 0,1,2,3,4,0 at 4-cycle spacing, disp_class tracks mem.
//   5) Write DEPTH entries with no res_last -> READY, res_ready=0; res_valid in READY -> overflow=1, count=DEPTH.
//   6) mode=11 asserted together with res_valid -> count=0, done=0, overflow=0, no write, disp_class=LOCK_CODE.

Source files
------------

// File: rtl/cnn_result_readout.sv
// Prediction buffer between the CNN accelerator and the board LEDs: captures a batch of class IDs,
// then replays them by index or by timed auto-scan, masking the real classes while locked.
module cnn_result_readout #(
  parameter int                 NUM_CLASSES = 10,
  parameter int                 CLASS_W     = 4,
  parameter int                 DEPTH       = 32,
  parameter int                 IDX_W       = $clog2(DEPTH),
  parameter int                 SCAN_DIV    = 50_000_000,
  parameter logic [CLASS_W-1:0] LOCK_CODE   = 4'hA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [CLASS_W-1:0] res_class,
  input  logic               res_last,
  input  logic               unlock,
  input  logic [1:0]         mode,
  input  logic [IDX_W-1:0]   sel_idx,
  output logic [CLASS_W-1:0] disp_class,
  output logic [IDX_W-1:0]   disp_idx,
  output logic [IDX_W:0]     count,
  output logic               done,
  output logic               overflow
);

  localparam int                 CNT_W    = IDX_W + 1;
  localparam int                 DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   LAST_C   = CNT_W'(DEPTH - 1);
  localparam logic [CLASS_W-1:0] NCLS_C   = CLASS_W'(NUM_CLASSES);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg;
  logic               done_reg, overflow_reg;
  logic [IDX_W-1:0]   disp_idx_reg, scan_ptr_reg;
  logic [CLASS_W-1:0] disp_class_reg;
  logic [DIV_W-1:0]   scan_div_reg;
  logic [CLASS_W-1:0] mem [DEPTH];

  logic               clear, accept, last_write;
  logic [CLASS_W-1:0] wr_data, rd_class;
  logic [IDX_W-1:0]   rd_idx, scan_ptr_next;

  assign clear      = (mode == 2'b11);
  assign res_ready  = ((state_reg == IDLE) || (state_reg == FILL)) && (count_reg < DEPTH_C) && !clear && !rst;
  assign accept     = res_valid && res_ready;
  assign last_write = res_last || (count_reg == LAST_C);
  assign wr_data    = (res_class < NCLS_C) ? res_class : LOCK_CODE;

  // Readout mux: stale or out-of-range entries are hidden by the count guard, so mem needs no reset.
  assign rd_idx   = (mode == 2'b10) ? scan_ptr_reg : sel_idx;
  assign rd_class = (unlock && ({1'b0, rd_idx} < count_reg)) ? mem[rd_idx] : LOCK_CODE;

  // With count==0 the comparison is always true, which pins the pointer at 0.
  assign scan_ptr_next = (({1'b0, scan_ptr_reg} + CNT_W'(1)) >= count_reg) ? '0 : scan_ptr_reg + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = last_write ? READY : FILL;
        FILL:    if (accept && last_write) state_next = READY;
        READY:   state_next = READY;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[count_reg[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg      <= '0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      disp_idx_reg   <= '0;
      disp_class_reg <= LOCK_CODE;
      scan_ptr_reg   <= '0;
      scan_div_reg   <= '0;
    end else begin
      if (accept) begin
        count_reg <= count_reg + CNT_W'(1);
        if (last_write) done_reg <= 1'b1;
      end
      if ((state_reg == READY) && res_valid) overflow_reg <= 1'b1;
      case (mode)
        2'b01: begin
          disp_idx_reg   <= sel_idx;
          disp_class_reg <= rd_class;
        end
        2'b10: begin
          disp_idx_reg   <= scan_ptr_reg;
          disp_class_reg <= rd_class;
          if (scan_div_reg == DIV_LAST) begin
            scan_div_reg <= '0;
            scan_ptr_reg <= scan_ptr_next;
          end else begin
            scan_div_reg <= scan_div_reg + DIV_W'(1);
          end
        end
        default: begin
          disp_idx_reg   <= '0;
          disp_class_reg <= LOCK_CODE;
        end
      endcase
    end
  end

  assign count      = count_reg;
  assign done       = done_reg;
  assign overflow   = overflow_reg;
  assign disp_idx   = disp_idx_reg;
  assign disp_class = disp_class_reg;

endmodule

// File: tb/tb_cnn_result_readout.sv
// Bench for cnn_result_readout: directed batch/readout/scan/overflow/clear scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based reference model.
module tb_cnn_result_readout;

  localparam int NC    = 10;
  localparam int CW    = 4;
  localparam int DEPTH = 8;
  localparam int IW    = 3;
  localparam int SD    = 4;
  localparam int LOCK  = 10;

  logic          clk = 1'b0;
  logic          rst, res_valid, res_ready, res_last, unlock, done, overflow;
  logic [CW-1:0] res_class, disp_class;
  logic [1:0]    mode;
  logic [IW-1:0] sel_idx, disp_idx;
  logic [IW:0]   count;

  always #5 clk = ~clk;

  cnn_result_readout #(
    .NUM_CLASSES(NC), .CLASS_W(CW), .DEPTH(DEPTH), .IDX_W(IW), .SCAN_DIV(SD), .LOCK_CODE(4'hA)
  ) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_last(res_last), .unlock(unlock), .mode(mode), .sel_idx(sel_idx), .disp_class(disp_class),
    .disp_idx(disp_idx), .count(count), .done(done), .overflow(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the buffer is a queue of stored classes; READY is simply "batch done".
  int q[$];
  bit m_done = 1'b0;
  bit m_ovf  = 1'b0;
  int m_ptr = 0, m_div = 0, m_dclass = LOCK, m_didx = 0;

  function automatic int entry(int i);
    if (!unlock || i >= q.size()) return LOCK;
    return q[i];
  endfunction

  function automatic bit model_ready();
    return !rst && !m_done && (q.size() < DEPTH) && (mode != 2'b11);
  endfunction

  task automatic model_reset();
    q.delete();
    m_done = 1'b0; m_ovf = 1'b0; m_ptr = 0; m_div = 0; m_dclass = LOCK; m_didx = 0;
  endtask

  task automatic model_step();
    bit rdy      = model_ready();
    bit was_done = m_done;
    int n        = q.size();
    if (rst || mode == 2'b11) begin
      model_reset();
    end else begin
      case (mode)
        2'b01: begin m_didx = int'(sel_idx); m_dclass = entry(int'(sel_idx)); end
        2'b10: begin
          m_didx = m_ptr; m_dclass = entry(m_ptr);
          if (m_div == SD - 1) begin
            m_div = 0;
            m_ptr = (m_ptr + 1 >= n) ? 0 : m_ptr + 1;
          end else m_div++;
        end
        default: begin m_didx = 0; m_dclass = LOCK; end
      endcase
      if (rdy && res_valid) begin
        q.push_back((int'(res_class) < NC) ? int'(res_class) : LOCK);
        if (res_last || q.size() == DEPTH) m_done = 1'b1;
        $display("[TB] write idx=%0d class=%0d last=%0d", n, res_class, res_last);
      end
      if (was_done && res_valid) m_ovf = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check("res_ready", res_ready, model_ready());
    model_step();
    @(posedge clk);
    #1;
    check("count", count, q.size());
    check("done", done, m_done);
    check("overflow", overflow, m_ovf);
    check("disp_class", disp_class, m_dclass);
    check("disp_idx", disp_idx, m_didx);
  endtask

  int t1_cls[5] = '{3, 7, 1, 9, 0};
  int sel_tab[4] = '{1, 3, 4, 6};
  int exp_tab[4] = '{7, 9, 0, LOCK};

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_class = '0; res_last = 1'b0;
    unlock = 1'b1; mode = 2'b00; sel_idx = '0;
    cycle(); cycle();
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_disp_class", disp_class, LOCK);
    rst = 1'b0;

    // Batch of five with res_last on the final one.
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1; res_class = CW'(t1_cls[i]); res_last = (i == 4);
      cycle();
      if (i == 3) check("t1_done_early", done, 0);
    end
    res_valid = 1'b0; res_last = 1'b0;
    check("t1_count", count, 5);
    check("t1_done", done, 1);

    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      sel_idx = IW'(sel_tab[i]);
      cycle();
      $display("[TB] readout sel=%0d class=%0d", sel_idx, disp_class);
      check("t2_readout", disp_class, exp_tab[i]);
    end

    sel_idx = 3'd1; unlock = 1'b0;
    cycle();
    check("t3_masked", disp_class, LOCK);
    unlock = 1'b1;
    cycle();
    check("t3_unmasked", disp_class, 7);

    mode = 2'b10;
    for (int k = 1; k <= 21; k++) begin
      cycle();
      if ((k - 1) % 4 == 0) begin
        $display("[TB] scan idx=%0d class=%0d", disp_idx, disp_class);
        check("t4_scan_idx", disp_idx, ((k - 1) / 4) % 5);
        check("t4_scan_class", disp_class, t1_cls[((k - 1) / 4) % 5]);
      end
    end

    mode = 2'b11;
    cycle();
    mode = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      res_valid = 1'b1; res_class = CW'($urandom_range(0, 15));
      cycle();
    end
    res_valid = 1'b0;
    check("t5_ready", res_ready, 0);
    check("t5_done", done, 1);
    res_valid = 1'b1; res_class = 4'd2;
    cycle();
    res_valid = 1'b0;
    check("t5_overflow", overflow, 1);
    check("t5_count", count, DEPTH);

    mode = 2'b11; res_valid = 1'b1; res_class = 4'd5;
    cycle();
    check("t6_count", count, 0);
    check("t6_done", done, 0);
    check("t6_overflow", overflow, 0);
    check("t6_disp_class", disp_class, LOCK);
    mode = 2'b00; res_valid = 1'b0;
    cycle();
    check("t6_no_write", count, 0);

    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 99));
      rst       = ($urandom_range(0, 199) == 0);
      mode      = (r < 4) ? 2'b11 : (r < 35) ? 2'b01 : (r < 70) ? 2'b10 : 2'b00;
      res_valid = $urandom_range(0, 1) == 1;
      res_class = CW'($urandom_range(0, 15));
      res_last  = ($urandom_range(0, 9) == 0);
      unlock    = ($urandom_range(0, 4) != 0);
      sel_idx   = IW'($urandom_range(0, DEPTH - 1));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
